sram_arbiter: RTL and testbench

Two-client arbiter that sits directly upstream of the SRAM controller and issues its `core_mem_*` requests. It accepts single-word read/write requests from two clients, client 0 and client 1, over valid/ready handshakes. It grants them round-robin, drives one controller request at a time, tracks the controller's busy (wait) window, and returns read data or a write acknowledgement to the granted client. Only one transaction is ever outstanding.

---
 rtl/sram_arb_pkg.sv | 21 ++
 rtl/sram_arbiter_rr_arb2.sv | 14 +
 rtl/sram_arbiter.sv | 121 ++++++++++++
 tb/tb_sram_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and default widths for the SRAM arbiter
package sram_arb_pkg;

    localparam int DEF_ADDR_W = 20;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        WAIT_DONE,
        RESPOND
    } state_t;

    typedef struct packed {
        logic                  wr;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin grant, ties go to the client not granted last
module rr_arb2 (
    input  logic i_v0,
    input  logic i_v1,
    input  logic i_last,
    input  logic i_en,
    output logic o_g0,
    output logic o_g1
);

    assign o_g0 = i_en && i_v0 && (!i_v1 || i_last);
    assign o_g1 = i_en && i_v1 && (!i_v0 || !i_last);

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin two-client front end issuing one SRAM controller transaction at a time
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int START_TO = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_c0_valid,
    input  logic              i_c0_wr,
    input  logic [ADDR_W-1:0] i_c0_addr,
    input  logic [DATA_W-1:0] i_c0_wdata,
    output logic              o_c0_ready,
    output logic              o_c0_rsp_valid,
    output logic [DATA_W-1:0] o_c0_rsp_rdata,
    output logic              o_c0_rsp_err,
    input  logic              i_c1_valid,
    input  logic              i_c1_wr,
    input  logic [ADDR_W-1:0] i_c1_addr,
    input  logic [DATA_W-1:0] i_c1_wdata,
    output logic              o_c1_ready,
    output logic              o_c1_rsp_valid,
    output logic [DATA_W-1:0] o_c1_rsp_rdata,
    output logic              o_c1_rsp_err,
    output logic              o_mem_request,
    output logic              o_mem_wr,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_wait,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam int CNT_W = $clog2(START_TO) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TO - 1);

    state_t            state, state_n;
    logic              last_grant, gid, err_q, wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic [CNT_W-1:0]  cnt;
    logic              arb_en, gnt0, gnt1, rsp;

    // never grant while the controller is still busy from an earlier (possibly dropped) operation
    assign arb_en = !i_rst && state == IDLE && !i_mem_wait;

    rr_arb2 u_arb (
        .i_v0   (i_c0_valid),
        .i_v1   (i_c1_valid),
        .i_last (last_grant),
        .i_en   (arb_en),
        .o_g0   (gnt0),
        .o_g1   (gnt1)
    );

    // state register
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_n;
    end

    // next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:       state_n = (gnt0 || gnt1) ? ISSUE : IDLE;
            ISSUE:      state_n = WAIT_START;
            WAIT_START: state_n = i_mem_wait ? WAIT_DONE : (cnt == CNT_LAST) ? RESPOND : WAIT_START;
            WAIT_DONE:  state_n = i_mem_wait ? WAIT_DONE : RESPOND;
            RESPOND:    state_n = IDLE;
            default:    state_n = IDLE;
        endcase
    end

    // latch the granted request, run the start timeout, capture the result
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_grant <= 1'b1;
            gid        <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            cnt        <= '0;
        end else begin
            if (gnt0 || gnt1) begin
                last_grant <= gnt1;
                gid        <= gnt1;
                wr_q       <= gnt1 ? i_c1_wr    : i_c0_wr;
                addr_q     <= gnt1 ? i_c1_addr  : i_c0_addr;
                wdata_q    <= gnt1 ? i_c1_wdata : i_c0_wdata;
                rdata_q    <= '0;
                err_q      <= 1'b0;
            end
            if (state == ISSUE) cnt <= '0;
            if (state == WAIT_START && !i_mem_wait) begin
                if (cnt == CNT_LAST) err_q <= 1'b1;
                else                 cnt   <= cnt + 1'b1;
            end
            if (state == WAIT_DONE && !i_mem_wait) rdata_q <= wr_q ? '0 : i_mem_rdata;
        end
    end

    // outputs are forced low while reset is held, even mid-transaction
    assign rsp            = !i_rst && state == RESPOND;
    assign o_c0_ready     = gnt0;
    assign o_c1_ready     = gnt1;
    assign o_c0_rsp_valid = rsp && !gid;
    assign o_c1_rsp_valid = rsp && gid;
    assign o_c0_rsp_rdata = (rsp && !gid) ? rdata_q : '0;
    assign o_c1_rsp_rdata = (rsp && gid) ? rdata_q : '0;
    assign o_c0_rsp_err   = rsp && !gid && err_q;
    assign o_c1_rsp_err   = rsp && gid && err_q;
    assign o_mem_request  = !i_rst && state == ISSUE;
    assign o_mem_wr       = !i_rst && wr_q;
    assign o_mem_addr     = i_rst ? '0 : addr_q;
    assign o_mem_wdata    = i_rst ? '0 : wdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed-vector bench for sram_arbiter with a simple busy-window controller model
module tb_sram_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_c0_valid, i_c0_wr, i_c1_valid, i_c1_wr;
    logic [19:0] i_c0_addr, i_c1_addr;
    logic [15:0] i_c0_wdata, i_c1_wdata;
    logic        o_c0_ready, o_c0_rsp_valid, o_c0_rsp_err;
    logic        o_c1_ready, o_c1_rsp_valid, o_c1_rsp_err;
    logic [15:0] o_c0_rsp_rdata, o_c1_rsp_rdata;
    logic        o_mem_request, o_mem_wr;
    logic [19:0] o_mem_addr;
    logic [15:0] o_mem_wdata;
    logic        i_mem_wait;
    logic [15:0] i_mem_rdata;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;

    int          m_b = 8;
    logic        m_on = 1'b1;
    logic [15:0] m_rdata = 16'h0;
    int          busy = 0;

    sram_arbiter #(.ADDR_W(20), .DATA_W(16), .START_TO(4)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_c0_valid     (i_c0_valid),
        .i_c0_wr        (i_c0_wr),
        .i_c0_addr      (i_c0_addr),
        .i_c0_wdata     (i_c0_wdata),
        .o_c0_ready     (o_c0_ready),
        .o_c0_rsp_valid (o_c0_rsp_valid),
        .o_c0_rsp_rdata (o_c0_rsp_rdata),
        .o_c0_rsp_err   (o_c0_rsp_err),
        .i_c1_valid     (i_c1_valid),
        .i_c1_wr        (i_c1_wr),
        .i_c1_addr      (i_c1_addr),
        .i_c1_wdata     (i_c1_wdata),
        .o_c1_ready     (o_c1_ready),
        .o_c1_rsp_valid (o_c1_rsp_valid),
        .o_c1_rsp_rdata (o_c1_rsp_rdata),
        .o_c1_rsp_err   (o_c1_rsp_err),
        .o_mem_request  (o_mem_request),
        .o_mem_wr       (o_mem_wr),
        .o_mem_addr     (o_mem_addr),
        .o_mem_wdata    (o_mem_wdata),
        .i_mem_wait     (i_mem_wait),
        .i_mem_rdata    (i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    // cycle counter used for latency measurement
    always @(posedge i_clk) cyc <= cyc + 1;

    // controller model: busy for m_b cycles starting the cycle after a request; ignores arbiter reset
    always @(posedge i_clk) begin
        if (o_mem_request && m_on) busy <= m_b;
        else if (busy > 0)         busy <= busy - 1;
    end
    assign i_mem_wait  = busy > 0;
    assign i_mem_rdata = m_rdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge i_clk);
        #1;
    endtask

    task automatic drive(input int c, input logic v, input logic wr, input logic [19:0] a, input logic [15:0] d);
        if (c == 0) begin
            i_c0_valid = v; i_c0_wr = wr; i_c0_addr = a; i_c0_wdata = d;
        end else begin
            i_c1_valid = v; i_c1_wr = wr; i_c1_addr = a; i_c1_wdata = d;
        end
    endtask

    task automatic chk_zero(input string p);
        check({p, "_ctl"}, 64'({o_c0_ready, o_c1_ready, o_c0_rsp_valid, o_c1_rsp_valid,
                                o_c0_rsp_err, o_c1_rsp_err, o_mem_request, o_mem_wr}), 64'd0);
        check({p, "_addr"}, 64'(o_mem_addr), 64'd0);
        check({p, "_wdata"}, 64'(o_mem_wdata), 64'd0);
        check({p, "_rdata"}, 64'({o_c0_rsp_rdata, o_c1_rsp_rdata}), 64'd0);
    endtask

    task automatic accept(input int want, output int t0, output int who);
        t0  = -1;
        who = -1;
        for (int n = 0; n < 40; n++) begin
            if (o_c0_ready || o_c1_ready) begin
                t0  = cyc;
                who = o_c1_ready ? 1 : 0;
                check("grant_onehot", 64'(o_c0_ready & o_c1_ready), 64'd0);
                break;
            end
            tick();
        end
        check("accept_seen", 64'(t0 >= 0), 64'd1);
        check("grant_id", 64'(who), 64'(want));
    endtask

    task automatic observe(input int c, input int t0, input logic wr, input logic [19:0] a,
                           input logic [15:0] d, input int lat, input logic [15:0] erd,
                           input logic eerr, output int rc);
        rc = -1;
        for (int n = 0; n < 40; n++) begin
            if (cyc == t0 + 1) begin
                check("req_pulse", 64'(o_mem_request), 64'd1);
                check("req_addr", 64'(o_mem_addr), 64'(a));
                check("req_wr", 64'(o_mem_wr), 64'(wr));
                check("req_wdata", 64'(o_mem_wdata), 64'(d));
            end
            if (cyc == t0 + 2) check("req_width", 64'(o_mem_request), 64'd0);
            if (o_c0_rsp_valid || o_c1_rsp_valid) begin
                rc = cyc;
                check("rsp_latency", 64'(cyc - t0), 64'(lat));
                check("rsp_owner", 64'({o_c1_rsp_valid, o_c0_rsp_valid}), 64'(c == 1 ? 2 : 1));
                check("rsp_rdata", 64'(c == 1 ? o_c1_rsp_rdata : o_c0_rsp_rdata), 64'(erd));
                check("rsp_err", 64'(c == 1 ? o_c1_rsp_err : o_c0_rsp_err), 64'(eerr));
                check("rsp_held", 64'({o_mem_wr, o_mem_addr, o_mem_wdata}), 64'({wr, a, d}));
                check("rsp_no_ready", 64'({o_c0_ready, o_c1_ready}), 64'd0);
                break;
            end
            tick();
        end
        check("rsp_seen", 64'(rc >= 0), 64'd1);
    endtask

    task automatic txn(input int c, input logic wr, input logic [19:0] a, input logic [15:0] d,
                       input int b, input logic [15:0] mrd, input logic on, input int lat,
                       input logic [15:0] erd, input logic eerr, output int rc);
        int t0, who;
        tick();
        m_b = b; m_rdata = mrd; m_on = on;
        drive(c, 1'b1, wr, a, d);
        #1;
        accept(c, t0, who);
        tick();
        drive(c, 1'b0, wr, a, d);
        #1;
        observe(c, t0, wr, a, d, lat, erd, eerr, rc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int t0, t1, t2, who, rc;
        i_rst = 1'b1;
        drive(0, 1'b0, 1'b0, 20'h0, 16'h0);
        drive(1, 1'b0, 1'b0, 20'h0, 16'h0);
        repeat (2) tick();
        chk_zero("reset");
        tick();
        i_rst = 1'b0;
        #1;
        chk_zero("idle");

        // single read, B = 8: response at T0+11
        txn(0, 1'b0, 20'h00010, 16'h0, 8, 16'hBEEF, 1'b1, 11, 16'hBEEF, 1'b0, rc);

        // write from c1, B = 3: rdata must be 0 despite controller data
        txn(1, 1'b1, 20'hFFFFF, 16'hA5A5, 3, 16'h1234, 1'b1, 6, 16'h0, 1'b0, rc);

        // round robin with both clients continuously valid, B = 2
        tick();
        m_b = 2; m_rdata = 16'h0C0C; m_on = 1'b1;
        drive(0, 1'b1, 1'b0, 20'h00100, 16'h0);
        drive(1, 1'b1, 1'b1, 20'h00200, 16'h5A5A);
        #1;
        for (int k = 0; k < 4; k++) begin
            accept(k % 2, t0, who);
            tick();
            #1;
            if (k % 2 == 1) observe(1, t0, 1'b1, 20'h00200, 16'h5A5A, 5, 16'h0, 1'b0, rc);
            else            observe(0, t0, 1'b0, 20'h00100, 16'h0, 5, 16'h0C0C, 1'b0, rc);
            if (k == 3) begin
                drive(0, 1'b0, 1'b0, 20'h0, 16'h0);
                drive(1, 1'b0, 1'b0, 20'h0, 16'h0);
            end
            tick();
        end

        // timeout: controller never starts, then a normal request goes through
        txn(0, 1'b0, 20'h00033, 16'h0, 8, 16'hDEAD, 1'b0, 6, 16'h0, 1'b1, rc);
        txn(1, 1'b0, 20'h00044, 16'h0, 1, 16'h7777, 1'b1, 4, 16'h7777, 1'b0, rc);

        // reset during WAIT_DONE; controller stays busy until T0+9
        tick();
        m_b = 8; m_rdata = 16'h1111; m_on = 1'b1;
        drive(0, 1'b1, 1'b0, 20'h00055, 16'h0);
        #1;
        accept(0, t0, who);
        tick();
        drive(0, 1'b0, 1'b0, 20'h0, 16'h0);
        #1;
        for (int n = 0; n < 5 && cyc < t0 + 6; n++) tick();
        i_rst = 1'b1;
        #1;
        chk_zero("midrst");
        tick();
        i_rst = 1'b0;
        m_b = 2; m_rdata = 16'h2222;
        drive(0, 1'b1, 1'b0, 20'h00066, 16'h0);
        #1;
        for (int k = 0; k < 3; k++) begin
            check("rst_busy_ready", 64'({o_c0_ready, o_c1_ready}), 64'd0);
            check("rst_no_rsp", 64'({o_c0_rsp_valid, o_c1_rsp_valid}), 64'd0);
            if (k < 2) tick();
        end
        tick();
        accept(0, t1, who);
        check("rst_accept_cycle", 64'(t1 - t0), 64'd10);
        tick();
        drive(0, 1'b0, 1'b0, 20'h0, 16'h0);
        #1;
        observe(0, t1, 1'b0, 20'h00066, 16'h0, 5, 16'h2222, 1'b0, rc);

        // back-to-back: c0 re-requests in its own response cycle
        drive(0, 1'b1, 1'b0, 20'h00077, 16'h0);
        m_rdata = 16'h3333;
        #1;
        check("b2b_ready_in_rsp", 64'(o_c0_ready), 64'd0);
        tick();
        accept(0, t2, who);
        check("b2b_accept_cycle", 64'(t2 - rc), 64'd1);
        tick();
        drive(0, 1'b0, 1'b0, 20'h0, 16'h0);
        #1;
        observe(0, t2, 1'b0, 20'h00077, 16'h0, 5, 16'h3333, 1'b0, rc);
        tick();
        check("final_rsp_width", 64'({o_c0_rsp_valid, o_c1_rsp_valid}), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
